// File: rtl/sccb_cfg.sv
// Walks an external register table and hands each {addr,data} entry to an SCCB
// write driver, with power-up wait, 0xFFFF pause entries and a write timeout.
module sccb_cfg #(
  parameter logic [7:0]  REG_NUM    = 8'd252,
  parameter logic [19:0] PWR_DELAY  = 20'd1_000_000,
  parameter logic [15:0] PAUSE_UNIT = 16'd50_000,
  parameter logic [7:0]  TIMEOUT    = 8'd200,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  cfg_index,
  input  logic [23:0] cfg_word,
  output logic        trig,
  output logic [15:0] driver_addr,
  output logic [7:0]  driver_data,
  input  logic        driver_end,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_TRIG  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [19:0] pwr_q, pwr_d;
  logic [7:0]  to_q, to_d;
  logic [15:0] tick_q, tick_d;
  logic [23:0] rem_q, rem_d;
  logic        adv;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pwr_d   = pwr_q;
    to_d    = to_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (AUTO_START || start) begin
          pwr_d   = 20'd0;
          state_d = S_PWR;
        end
      end
      S_PWR: begin
        if (pwr_q == PWR_DELAY - 20'd1) begin
          idx_d   = 8'd0;
          state_d = S_FETCH;
        end else begin
          pwr_d = pwr_q + 20'd1;
        end
      end
      S_FETCH: begin
        addr_d = cfg_word[23:8];
        data_d = cfg_word[7:0];
        if (cfg_word[23:8] == 16'hFFFF) begin
          rem_d   = {16'd0, cfg_word[7:0]};
          tick_d  = 16'd0;
          state_d = S_PAUSE;
        end else begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        to_d    = 8'd0;
        state_d = S_WAIT;
      end
      // driver_end is checked before the timeout so a same-cycle tie advances
      S_WAIT: begin
        if (driver_end) begin
          adv = 1'b1;
        end else if (to_q == TIMEOUT - 8'd1) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      // Leaves on the last cycle of the final tick, so the pause spans data*PAUSE_UNIT cycles
      S_PAUSE: begin
        if (rem_q == 24'd0 || (rem_q == 24'd1 && tick_q == PAUSE_UNIT - 16'd1)) begin
          adv = 1'b1;
        end else if (tick_q == PAUSE_UNIT - 16'd1) begin
          tick_d = 16'd0;
          rem_d  = rem_q - 24'd1;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          idx_d   = 8'd0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (idx_q == REG_NUM - 8'd1) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 8'd1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 8'd0;
      addr_q  <= 16'd0;
      data_q  <= 8'd0;
      pwr_q   <= 20'd0;
      to_q    <= 8'd0;
      tick_q  <= 16'd0;
      rem_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pwr_q   <= pwr_d;
      to_q    <= to_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
    end
  end

  assign cfg_index   = idx_q;
  assign driver_addr = addr_q;
  assign driver_data = data_q;
  assign trig        = (state_q == S_TRIG);
  assign cfg_busy    = (state_q == S_PWR) || (state_q == S_FETCH) || (state_q == S_TRIG) ||
                       (state_q == S_WAIT) || (state_q == S_PAUSE);
  assign cfg_done    = (state_q == S_DONE);
  assign cfg_err     = (state_q == S_ERR);

endmodule

// File: tb/tb_sccb_cfg.sv
// Bench for sccb_cfg: external 3-entry table, responding driver model and
// a queue of expected {addr,data} words popped on every trig pulse.
`timescale 1ns/1ps
module tb_sccb_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_index;
  logic [23:0] cfg_word;
  logic        trig;
  logic [15:0] driver_addr;
  logic [7:0]  driver_data;
  logic        driver_end;
  logic        cfg_busy, cfg_done, cfg_err;
  logic        model_end = 1'b0;
  logic        spur_end = 1'b0;

  logic [23:0] tbl [4];
  logic [23:0] exp_q [$];
  logic [23:0] exp_w;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_trig = 0;
  int trig_t [4];
  int idx_t [4];
  logic [7:0] prev_idx = 8'd0;

  int dly = 38;
  int no_rsp = -1;
  int dcnt = 0;
  bit pend = 1'b0;

  assign cfg_word   = tbl[cfg_index[1:0]];
  assign driver_end = model_end | spur_end;

  sccb_cfg #(
    .REG_NUM   (8'd3),
    .PWR_DELAY (20'd10),
    .PAUSE_UNIT(16'd5),
    .TIMEOUT   (8'd200),
    .AUTO_START(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_index  (cfg_index),
    .cfg_word   (cfg_word),
    .trig       (trig),
    .driver_addr(driver_addr),
    .driver_data(driver_data),
    .driver_end (driver_end),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Driver model: driver_end is high during cycle trig+dly
  always @(negedge clk) begin
    model_end = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      dcnt--;
      if (dcnt == 0) begin
        model_end = 1'b1;
        pend = 1'b0;
      end
    end else if (trig && int'(cfg_index) != no_rsp) begin
      pend = 1'b1;
      dcnt = dly;
    end
  end

  always @(negedge clk) begin
    if (trig) begin
      n_trig++;
      trig_t[cfg_index[1:0]] = cyc;
      if (exp_q.size() == 0) begin
        chk("trig_extra", 32'd1, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        chk("trig_word", {8'd0, driver_addr, driver_data}, {8'd0, exp_w});
      end
    end
    if (cfg_index != prev_idx) begin
      idx_t[cfg_index[1:0]] = cyc;
      prev_idx = cfg_index;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_end();
    spur_end = 1'b1;
    @(negedge clk);
    spur_end = 1'b0;
  endtask

  task automatic push_all(input bit skip1);
    exp_q.push_back(tbl[0]);
    if (!skip1) exp_q.push_back(tbl[1]);
    exp_q.push_back(tbl[2]);
  endtask

  // sel 0 waits for cfg_done, sel 1 for cfg_err
  task automatic wait_sig(input string tag, input int sel, input int bound);
    int k = 0;
    while (k < bound && !(sel == 0 ? cfg_done : cfg_err)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(sel == 0 ? cfg_done : cfg_err), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_trig"}, 32'(trig), 32'd0);
    chk({tag, "_busy"}, 32'(cfg_busy), 32'd0);
    chk({tag, "_done"}, 32'(cfg_done), 32'd0);
    chk({tag, "_err"},  32'(cfg_err), 32'd0);
    chk({tag, "_idx"},  32'(cfg_index), 32'd0);
    chk({tag, "_addr"}, 32'(driver_addr), 32'd0);
    chk({tag, "_data"}, 32'(driver_data), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, s, n0, k;
    tbl[0] = 24'h3008_82;
    tbl[1] = 24'h3103_03;
    tbl[2] = 24'h3017_FF;
    tbl[3] = 24'h0000_00;
    tick(3);
    check_zero("rst");

    // Nominal run after reset release, with spurious inputs during PWR_WAIT
    push_all(1'b0);
    n0 = n_trig;
    rst_n = 1'b1;
    rel = cyc;
    tick(3);
    pulse_end();
    pulse_start();
    wait_sig("nom_done", 0, 1000);
    chk("nom_first_trig", 32'(trig_t[0] - rel), 32'd12);
    chk("nom_trig_cnt", 32'(n_trig - n0), 32'd3);
    chk("nom_q_empty", 32'(exp_q.size()), 32'd0);
    chk("nom_busy", 32'(cfg_busy), 32'd0);
    chk("nom_idx", 32'(cfg_index), 32'd2);
    chk("nom_hold", {8'd0, driver_addr, driver_data}, 32'h3017FF);

    // Spurious driver_end in DONE
    pulse_end();
    tick(3);
    chk("spur_done", 32'(cfg_done), 32'd1);
    chk("spur_idx", 32'(cfg_index), 32'd2);
    chk("spur_trig_cnt", 32'(n_trig - n0), 32'd3);

    // Two-tick pause entry, spurious inputs during the pause
    tbl[1] = 24'hFFFF_02;
    push_all(1'b1);
    n0 = n_trig;
    s = cyc;
    pulse_start();
    k = 0;
    while (k < 500 && cfg_index != 8'd1) begin
      @(negedge clk);
      k++;
    end
    chk("pause_reach", 32'(cfg_index), 32'd1);
    tick(2);
    pulse_end();
    pulse_start();
    wait_sig("pause_done", 0, 1000);
    chk("pause_restart", 32'(trig_t[0] - s), 32'd2);
    chk("pause_gap", 32'(idx_t[2] - idx_t[1]), 32'd11);
    chk("pause_trig_cnt", 32'(n_trig - n0), 32'd2);

    // Zero-length pause
    tbl[1] = 24'hFFFF_00;
    push_all(1'b1);
    n0 = n_trig;
    pulse_start();
    wait_sig("zpause_done", 0, 1000);
    chk("zpause_gap", 32'(idx_t[2] - idx_t[1]), 32'd2);
    chk("zpause_trig_cnt", 32'(n_trig - n0), 32'd2);

    // Timeout on entry 1, then restart from ERR
    tbl[1] = 24'h3103_03;
    no_rsp = 1;
    exp_q.push_back(tbl[0]);
    exp_q.push_back(tbl[1]);
    pulse_start();
    wait_sig("to_err", 1, 2000);
    chk("to_cycle", 32'(cyc - trig_t[1]), 32'd201);
    chk("to_idx", 32'(cfg_index), 32'd1);
    chk("to_busy", 32'(cfg_busy), 32'd0);
    chk("to_done", 32'(cfg_done), 32'd0);
    no_rsp = -1;
    push_all(1'b0);
    n0 = n_trig;
    s = cyc;
    pulse_start();
    chk("re_err", 32'(cfg_err), 32'd0);
    chk("re_busy", 32'(cfg_busy), 32'd1);
    chk("re_idx", 32'(cfg_index), 32'd0);
    wait_sig("re_done", 0, 1000);
    chk("re_first_trig", 32'(trig_t[0] - s), 32'd2);
    chk("re_trig_cnt", 32'(n_trig - n0), 32'd3);

    // driver_end exactly at the timeout boundary
    dly = 200;
    push_all(1'b0);
    pulse_start();
    wait_sig("tie_done", 0, 3000);
    chk("tie_err", 32'(cfg_err), 32'd0);
    dly = 38;

    // Reset during WAIT_END of entry 2
    push_all(1'b0);
    n0 = n_trig;
    pulse_start();
    k = 0;
    while (k < 500 && n_trig < n0 + 3) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach", 32'(n_trig - n0), 32'd3);
    tick(5);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    exp_q.delete();
    push_all(1'b0);
    n0 = n_trig;
    tick(2);
    rst_n = 1'b1;
    rel = cyc;
    wait_sig("mid_done", 0, 1000);
    chk("mid_first_trig", 32'(trig_t[0] - rel), 32'd12);
    chk("mid_trig_cnt", 32'(n_trig - n0), 32'd3);
    chk("mid_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sccb_cfg.md
SCCB_CFG -- requirements
Module: sccb_cfg

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 8'd252: number of table entries, range 1..255.
REQ-002 The block SHALL have parameter PWR_DELAY, default 20'd1_000_000: power-up wait in clk cycles (20 ms at 50 MHz).
REQ-003 The block SHALL have parameter PAUSE_UNIT, default 16'd50_000: cycles per pause tick (1 ms at 50 MHz).
REQ-004 The block SHALL have parameter TIMEOUT, default 8'd200: maximum cycles to wait for driver_end.
REQ-005 The block SHALL have parameter AUTO_START, default 1: when 1, configuration starts automatically after reset.
REQ-006 The block SHALL have port clk, input, 1 bit: 50 MHz system clock; one clock domain.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port start, input, 1 bit: restart pulse; sampled only in DONE or ERR.
REQ-009 The block SHALL have port cfg_index, output, 8 bits: current table index to the external combinational table.
REQ-010 The block SHALL have port cfg_word, input, 24 bits: table entry {addr[15:0], data[7:0]}, valid in the same cycle as cfg_index.
REQ-011 The block SHALL have port trig, output, 1 bit: one-cycle write request to sccb_driver.
REQ-012 The block SHALL have port driver_addr, output, 16 bits: register address to sccb_driver.
REQ-013 The block SHALL have port driver_data, output, 8 bits: register data to sccb_driver.
REQ-014 The block SHALL have port driver_end, input, 1 bit: one-cycle write-complete pulse from sccb_driver.
REQ-015 The block SHALL have port cfg_busy, output, 1 bit: high in PWR_WAIT, FETCH, TRIG, WAIT_END and PAUSE.
REQ-016 The block SHALL have port cfg_done, output, 1 bit: high in DONE; all entries written.
REQ-017 The block SHALL have port cfg_err, output, 1 bit: high in ERR; driver_end timeout.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, PWR_WAIT, FETCH, TRIG, WAIT_END, PAUSE, DONE, ERR.
REQ-019 IDLE SHALL go to PWR_WAIT on the first clock after reset release if AUTO_START=1; otherwise IDLE SHALL go to PWR_WAIT on start=1.
REQ-020 PWR_WAIT SHALL count cycles from 0; at count PWR_DELAY-1 it SHALL set cfg_index=0 and go to FETCH.
REQ-021 FETCH SHALL last one cycle, registering cfg_word[23:8] into driver_addr and cfg_word[7:0] into driver_data.
REQ-022 FETCH SHALL go to PAUSE if cfg_word[23:8]==16'hFFFF, otherwise to TRIG.
REQ-023 TRIG SHALL last one cycle with trig=1 and then go to WAIT_END; trig SHALL be 0 in every other state.
REQ-024 driver_addr and driver_data SHALL stay stable from FETCH exit until the next FETCH.
REQ-025 WAIT_END SHALL leave on driver_end=1 by advancing the index (REQ-027).
REQ-026 WAIT_END SHALL go to ERR if driver_end has not arrived within TIMEOUT cycles after TRIG; cfg_index SHALL freeze at the failing entry.
REQ-027 Index advance SHALL go to DONE if cfg_index==REG_NUM-1; otherwise it SHALL increment cfg_index and go to FETCH.
REQ-028 PAUSE SHALL wait driver_data*PAUSE_UNIT cycles (data=0: zero-length, exit next cycle) with no trig, then advance the index per REQ-027.
REQ-029 The pause counter SHALL be 24 bits wide; a tick counter SHALL run to PAUSE_UNIT-1 and decrement the remaining-tick count.
REQ-030 DONE and ERR SHALL hold until start=1, which SHALL clear cfg_done/cfg_err, set cfg_index=0 and go directly to FETCH (no power wait).
REQ-031 start SHALL be ignored in PWR_WAIT, FETCH, TRIG, WAIT_END and PAUSE.
REQ-032 driver_end SHALL be ignored in every state except WAIT_END.
REQ-033 When driver_end and the timeout expiry fall in the same cycle, driver_end SHALL win (advance, no ERR).
REQ-034 At most one trig SHALL be outstanding: no new trig before driver_end or ERR.

Reset
REQ-035 rst_n=0 SHALL force IDLE immediately, from any state including mid-write.
REQ-036 rst_n=0 SHALL drive trig, cfg_busy, cfg_done and cfg_err to 0.
REQ-037 rst_n=0 SHALL clear cfg_index, driver_addr, driver_data and all counters to 0.
REQ-038 After reset release, the block SHALL redo the full PWR_WAIT before any write.

Verification
REQ-039 Nominal write: REG_NUM=3, PWR_DELAY=10, table {3008,82},{3103,03},{3017,FF}, driver model returning driver_end 38 cycles after trig -> exactly 3 trig pulses carrying those addr/data pairs; first trig no earlier than cycle 11 after reset release; cfg_done=1 after the third driver_end.
REQ-040 Pause entry: entry 1 = {FFFF,02}, PAUSE_UNIT=5 -> no trig for entry 1 and a 10-cycle gap before the entry-2 FETCH; table {FFFF,00} -> zero-length pause.
REQ-041 Timeout: driver model never responds to entry 1, TIMEOUT=200 -> cfg_err=1 on cycle 201 after trig, cfg_index=1, cfg_busy=0; a start pulse then clears cfg_err and rewrites from index 0 without a power wait.
REQ-042 Reset mid-write: rst_n low during WAIT_END of entry 2 -> all outputs 0 at once; after release, full PWR_WAIT, then writes restart at index 0.
REQ-043 Spurious inputs: driver_end pulses during PWR_WAIT/PAUSE/DONE and start pulses while busy -> no change to state, cfg_index or the trig count.
REQ-044 Tie: driver_end arriving on cycle 200 after trig (TIMEOUT=200) -> advance, cfg_err stays 0.
